// File: rtl/fifo_deq_serializer_if.sv
// Handshake bundle between the wide upstream FIFO dequeue side, the narrow
// downstream FIFO enqueue side, and the serializer's control/status pins.
interface fifo_deq_serializer_if #(
    parameter int out_width = 8,
    parameter int ratio     = 4
);
    logic [out_width*ratio-1:0] IN_DATA;
    logic                       IN_EMPTY_N;
    logic                       IN_DEQ;
    logic [out_width-1:0]       OUT_DATA;
    logic                       OUT_FULL_N;
    logic                       OUT_ENQ;
    logic                       CLR;
    logic                       BUSY;
    logic [15:0]                WORD_CNT;

    // Master side: the environment holding both FIFOs and the flush control.
    modport master (
        output IN_DATA, IN_EMPTY_N, OUT_FULL_N, CLR,
        input  IN_DEQ, OUT_DATA, OUT_ENQ, BUSY, WORD_CNT
    );

    // Slave side: the serializer itself.
    modport slave (
        input  IN_DATA, IN_EMPTY_N, OUT_FULL_N, CLR,
        output IN_DEQ, OUT_DATA, OUT_ENQ, BUSY, WORD_CNT
    );
endinterface

// File: rtl/fifo_deq_serializer.sv
// Wide-to-narrow FIFO bridge: dequeues one wide word, emits it as `ratio`
// narrow slices at one slice per cycle, and reloads on the last slice so
// consecutive words stream without a bubble. Legal ratio range is 2..16.
module fifo_deq_serializer #(
    parameter int out_width = 8,
    parameter int ratio     = 4,
    parameter int msb_first = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    fifo_deq_serializer_if.slave  bus
);
    localparam int in_width = out_width * ratio;
    localparam int idx_w    = $clog2(ratio);
    localparam logic [idx_w-1:0] idx_max = idx_w'(ratio - 1);

    logic                 held;
    logic [in_width-1:0]  hold_reg;
    logic [idx_w-1:0]     idx;
    logic [15:0]          word_cnt;

    logic                 last;
    logic                 out_enq;
    logic                 in_deq;
    logic [idx_w-1:0]     slice_k;
    logic [out_width-1:0] out_data;

    // Handshake strobes and slice selection; both strobes are held low during
    // reset and flush so neither FIFO moves in those cycles.
    always_comb begin
        last     = held && (idx == idx_max);
        out_enq  = RST && held && bus.OUT_FULL_N && !bus.CLR;
        in_deq   = RST && bus.IN_EMPTY_N && !bus.CLR && (!held || (out_enq && last));
        slice_k  = (msb_first != 0) ? (idx_max - idx) : idx;
        out_data = '0;
        if (held) begin
            out_data = hold_reg[slice_k*out_width +: out_width];
        end
    end

    // Word holding register, slice index and completed-word counter; a load
    // takes priority over the release at the last slice to allow streaming.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            held     <= 1'b0;
            hold_reg <= '0;
            idx      <= '0;
            word_cnt <= '0;
        end else begin
            word_cnt <= word_cnt + {15'd0, (out_enq && last)};
            if (bus.CLR) begin
                held <= 1'b0;
                idx  <= '0;
            end else if (in_deq) begin
                hold_reg <= bus.IN_DATA;
                held     <= 1'b1;
                idx      <= '0;
            end else if (out_enq) begin
                if (last) begin
                    held <= 1'b0;
                    idx  <= '0;
                end else begin
                    idx <= idx + idx_w'(1);
                end
            end
        end
    end

    assign bus.IN_DEQ   = in_deq;
    assign bus.OUT_ENQ  = out_enq;
    assign bus.OUT_DATA = out_data;
    assign bus.BUSY     = held;
    assign bus.WORD_CNT = word_cnt;

endmodule

// File: tb/tb_fifo_deq_serializer.sv
// Directed bench: two serializers (MSB-first and LSB-first) see identical
// stimulus; each table row gives the inputs for one cycle and the outputs
// expected during that cycle before the next rising edge.
module tb_fifo_deq_serializer;

    typedef struct {
        logic        rst;
        logic        clr;
        logic        empty_n;
        logic        full_n;
        logic [31:0] data;
        logic        exp_deq;
        logic        exp_enq;
        logic [7:0]  exp_m;
        logic [7:0]  exp_l;
        logic        exp_busy;
        logic [15:0] exp_cnt;
    } vec_t;

    logic        CLK;
    logic        RST;
    logic        clr;
    logic        in_empty_n;
    logic        out_full_n;
    logic [31:0] in_data;

    int tests;
    int failures;

    vec_t vecs[$];

    fifo_deq_serializer_if #(.out_width(8), .ratio(4)) bus_m ();
    fifo_deq_serializer_if #(.out_width(8), .ratio(4)) bus_l ();

    assign bus_m.IN_DATA    = in_data;
    assign bus_m.IN_EMPTY_N = in_empty_n;
    assign bus_m.OUT_FULL_N = out_full_n;
    assign bus_m.CLR        = clr;
    assign bus_l.IN_DATA    = in_data;
    assign bus_l.IN_EMPTY_N = in_empty_n;
    assign bus_l.OUT_FULL_N = out_full_n;
    assign bus_l.CLR        = clr;

    fifo_deq_serializer #(.out_width(8), .ratio(4), .msb_first(1)) dut_m (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_m.slave)
    );

    fifo_deq_serializer #(.out_width(8), .ratio(4), .msb_first(0)) dut_l (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_l.slave)
    );

    // Free-running 10-unit clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic vec_t mk(input logic rst, input logic c, input logic en,
                                input logic fn, input logic [31:0] d,
                                input logic deq, input logic enq,
                                input logic [7:0] m, input logic [7:0] l,
                                input logic busy, input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.clr = c; v.empty_n = en; v.full_n = fn; v.data = d;
        v.exp_deq = deq; v.exp_enq = enq; v.exp_m = m; v.exp_l = l;
        v.exp_busy = busy; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int n);
        @(negedge CLK);
        RST        = v.rst;
        clr        = v.clr;
        in_empty_n = v.empty_n;
        out_full_n = v.full_n;
        in_data    = v.data;
        #1;
        checkOutput($sformatf("v%0d deq_m", n),  32'(bus_m.IN_DEQ),   32'(v.exp_deq));
        checkOutput($sformatf("v%0d deq_l", n),  32'(bus_l.IN_DEQ),   32'(v.exp_deq));
        checkOutput($sformatf("v%0d enq_m", n),  32'(bus_m.OUT_ENQ),  32'(v.exp_enq));
        checkOutput($sformatf("v%0d enq_l", n),  32'(bus_l.OUT_ENQ),  32'(v.exp_enq));
        checkOutput($sformatf("v%0d data_m", n), 32'(bus_m.OUT_DATA), 32'(v.exp_m));
        checkOutput($sformatf("v%0d data_l", n), 32'(bus_l.OUT_DATA), 32'(v.exp_l));
        checkOutput($sformatf("v%0d busy_m", n), 32'(bus_m.BUSY),     32'(v.exp_busy));
        checkOutput($sformatf("v%0d busy_l", n), 32'(bus_l.BUSY),     32'(v.exp_busy));
        checkOutput($sformatf("v%0d cnt_m", n),  32'(bus_m.WORD_CNT), 32'(v.exp_cnt));
        checkOutput($sformatf("v%0d cnt_l", n),  32'(bus_l.WORD_CNT), 32'(v.exp_cnt));
    endtask

    // Main sequence: reset, table of vectors, idle soak, counter wrap.
    initial begin
        tests      = 0;
        failures   = 0;
        RST        = 1'b0;
        clr        = 1'b0;
        in_empty_n = 1'b0;
        out_full_n = 1'b1;
        in_data    = 32'h0;

        // Reset state, then single word A1B2C3D4
        vecs.push_back(mk(0,0,1,1,32'hA1B2C3D4, 0,0,8'h00,8'h00,0,16'd0));
        vecs.push_back(mk(0,0,1,1,32'hA1B2C3D4, 0,0,8'h00,8'h00,0,16'd0));
        vecs.push_back(mk(1,0,1,1,32'hA1B2C3D4, 1,0,8'h00,8'h00,0,16'd0));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'hA1,8'hD4,1,16'd0));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'hB2,8'hC3,1,16'd0));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'hC3,8'hB2,1,16'd0));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'hD4,8'hA1,1,16'd0));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,0,8'h00,8'h00,0,16'd1));
        // Two queued words streamed back to back
        vecs.push_back(mk(1,0,1,1,32'h01020304, 1,0,8'h00,8'h00,0,16'd1));
        vecs.push_back(mk(1,0,1,1,32'h05060708, 0,1,8'h01,8'h04,1,16'd1));
        vecs.push_back(mk(1,0,1,1,32'h05060708, 0,1,8'h02,8'h03,1,16'd1));
        vecs.push_back(mk(1,0,1,1,32'h05060708, 0,1,8'h03,8'h02,1,16'd1));
        vecs.push_back(mk(1,0,1,1,32'h05060708, 1,1,8'h04,8'h01,1,16'd1));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'h05,8'h08,1,16'd2));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'h06,8'h07,1,16'd2));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'h07,8'h06,1,16'd2));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'h08,8'h05,1,16'd2));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,0,8'h00,8'h00,0,16'd3));
        // Backpressure for 3 cycles on the second slice
        vecs.push_back(mk(1,0,1,1,32'hA1B2C3D4, 1,0,8'h00,8'h00,0,16'd3));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'hA1,8'hD4,1,16'd3));
        vecs.push_back(mk(1,0,0,0,32'h0,        0,0,8'hB2,8'hC3,1,16'd3));
        vecs.push_back(mk(1,0,0,0,32'h0,        0,0,8'hB2,8'hC3,1,16'd3));
        vecs.push_back(mk(1,0,0,0,32'h0,        0,0,8'hB2,8'hC3,1,16'd3));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'hB2,8'hC3,1,16'd3));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'hC3,8'hB2,1,16'd3));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'hD4,8'hA1,1,16'd3));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,0,8'h00,8'h00,0,16'd4));
        // Flush after the second slice; next word starts from its first slice
        vecs.push_back(mk(1,0,1,1,32'h11223344, 1,0,8'h00,8'h00,0,16'd4));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'h11,8'h44,1,16'd4));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'h22,8'h33,1,16'd4));
        vecs.push_back(mk(1,1,1,1,32'h55667788, 0,0,8'h33,8'h22,1,16'd4));
        vecs.push_back(mk(1,0,1,1,32'h55667788, 1,0,8'h00,8'h00,0,16'd4));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'h55,8'h88,1,16'd4));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'h66,8'h77,1,16'd4));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'h77,8'h66,1,16'd4));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'h88,8'h55,1,16'd4));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,0,8'h00,8'h00,0,16'd5));
        // Reset after the second slice discards the word and clears the count
        vecs.push_back(mk(1,0,1,1,32'hA1B2C3D4, 1,0,8'h00,8'h00,0,16'd5));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'hA1,8'hD4,1,16'd5));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,1,8'hB2,8'hC3,1,16'd5));
        vecs.push_back(mk(0,0,1,1,32'hA1B2C3D4, 0,0,8'hC3,8'hB2,1,16'd5));
        vecs.push_back(mk(1,0,0,1,32'h0,        0,0,8'h00,8'h00,0,16'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Empty upstream for 20 cycles: nothing moves
        for (int i = 0; i < 20; i++) begin
            applyStimulus(mk(1,0,0,1,32'hFFFFFFFF, 0,0,8'h00,8'h00,0,16'd0), 100 + i);
        end

        // Preload the completed-word counter to its top value while idle
        force dut_m.word_cnt = 16'hFFFF;
        force dut_l.word_cnt = 16'hFFFF;
        @(posedge CLK);
        #1;
        release dut_m.word_cnt;
        release dut_l.word_cnt;

        // One more word wraps the counter to zero
        applyStimulus(mk(1,0,1,1,32'hCAFE0102, 1,0,8'h00,8'h00,0,16'hFFFF), 200);
        applyStimulus(mk(1,0,0,1,32'h0,        0,1,8'hCA,8'h02,1,16'hFFFF), 201);
        applyStimulus(mk(1,0,0,1,32'h0,        0,1,8'hFE,8'h01,1,16'hFFFF), 202);
        applyStimulus(mk(1,0,0,1,32'h0,        0,1,8'h01,8'hFE,1,16'hFFFF), 203);
        applyStimulus(mk(1,0,0,1,32'h0,        0,1,8'h02,8'hCA,1,16'hFFFF), 204);
        applyStimulus(mk(1,0,0,1,32'h0,        0,0,8'h00,8'h00,0,16'h0000), 205);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/fifo_deq_serializer.md
# fifo_deq_serializer

- Drains wide words from the dequeue side of an upstream guarded FIFO (D_OUT/EMPTY_N/DEQ).
- Splits each word into `ratio` narrow slices and pushes them into the enqueue side of a downstream FIFO (D_IN/FULL_N/ENQ).
- Acts as the reader of the wide FIFO and the writer of the narrow one; sits between the wide datapath and narrow egress FIFOs.
- Sustains one slice per cycle with no bubble between words; honours FULL_N backpressure.

## Interface
- Parameters
  - `out_width`, default 8: width of each slice and of `OUT_DATA`.
  - `ratio`, default 4: slices per word; legal values are 2 to 16. The input width is `out_width*ratio`.
  - `msb_first`, default 1: 1 sends the most significant slice first; 0 sends the least significant slice first.
- Ports
  - `CLK` in 1: clock; every register samples on the rising edge.
  - `RST` in 1: reset, synchronous, active-low; sampled on the rising edge of `CLK`.
  - `IN_DATA` in `out_width*ratio`: head word of the upstream FIFO (its D_OUT); valid while `IN_EMPTY_N`=1.
  - `IN_EMPTY_N` in 1: upstream FIFO holds at least one word.
  - `IN_DEQ` out 1: combinational dequeue strobe to the upstream FIFO.
  - `OUT_DATA` out `out_width`: current slice, driven to the downstream D_IN.
  - `OUT_FULL_N` in 1: downstream FIFO can accept a slice.
  - `OUT_ENQ` out 1: combinational enqueue strobe to the downstream FIFO.
  - `CLR` in 1: synchronous flush of this block only.
  - `BUSY` out 1: a word is held and not yet fully emitted.
  - `WORD_CNT` out 16: number of words fully emitted; wraps modulo 2^16.

## Operation
- State
  - `held` flag.
  - `hold_reg`, `out_width*ratio` bits.
  - Slice index `idx`, width clog2(`ratio`), counting 0 to `ratio`-1.
  - `WORD_CNT` register.
- `last` = `held` && (`idx` == `ratio`-1).
- `OUT_ENQ` = `held` && `OUT_FULL_N` && !`CLR`.
- `IN_DEQ` = `IN_EMPTY_N` && !`CLR` && (!`held` || (`OUT_ENQ` && `last`)).
- `OUT_DATA` is slice k of `hold_reg`, where k = `ratio`-1-`idx` if `msb_first`=1, else k = `idx`. Slice k is bits [k*`out_width` +: `out_width`].
- When `OUT_DATA` is not meaningful (`held`=0) it is driven to 0.
- `BUSY` = `held`.
- On `IN_DEQ`: `hold_reg` <= `IN_DATA`, `held` <= 1, `idx` <= 0.
- On `OUT_ENQ` && !`last`: `idx` <= `idx`+1.
- On `OUT_ENQ` && `last`:
  - `WORD_CNT` <= `WORD_CNT`+1.
  - If `IN_DEQ` is not also asserted: `held` <= 0 and `idx` <= 0.
  - If `IN_DEQ` is asserted in the same cycle: the back-to-back load described above applies.
- `OUT_FULL_N`=0 while held: the block stalls; `OUT_DATA` and `idx` stay stable and `OUT_ENQ`=0.
- `IN_EMPTY_N`=0 while idle: `IN_DEQ`=0 and the block stays idle.
- `CLR`=1: `held` <= 0 and `idx` <= 0, discarding any partially sent word. `IN_DEQ` and `OUT_ENQ` are 0 in that cycle. `WORD_CNT` is unchanged.
- The block never asserts `IN_DEQ` while `IN_EMPTY_N`=0, nor `OUT_ENQ` while `OUT_FULL_N`=0.

## Timing
- Reset (`RST`=0 at a clock edge):
  - `held`=0, `idx`=0, `WORD_CNT`=0, `hold_reg`=0.
  - Outputs: `BUSY`=0, `OUT_DATA`=0, `OUT_ENQ`=0, `IN_DEQ`=0 (forced low while `RST`=0).
  - Reset overrides `CLR` and any transfer in progress.
- Latency: a word dequeued at edge t has its first slice enqueued in the cycle after t. Without backpressure, its last slice is enqueued `ratio` cycles after t.
- Throughput: `ratio` cycles per word with no idle cycle between words, provided `IN_EMPTY_N` stays 1.
- `WORD_CNT` increments at the edge that completes the last slice; it is visible in the following cycle.
- Reset mid-word: the partially sent word is lost; the upstream FIFO is not re-read for it.

## Test plan
- Single word, `out_width`=8, `ratio`=4, `msb_first`=1, `IN_DATA`=0xA1B2C3D4:
  - `IN_DEQ` high for 1 cycle.
  - `OUT_DATA` = A1, B2, C3, D4 with `OUT_ENQ` high on 4 consecutive cycles.
  - `WORD_CNT` goes 0→1; `BUSY` then drops.
- Same word with `msb_first`=0 -> D4, C3, B2, A1.
- Two queued words 0x01020304 and 0x05060708:
  - 8 consecutive `OUT_ENQ` cycles 01..08.
  - The second `IN_DEQ` coincides with the enqueue of 04.
  - `WORD_CNT`=2.
- `OUT_FULL_N`=0 for 3 cycles while slice B2 is presented:
  - `OUT_ENQ`=0 and `OUT_DATA` holds B2 for those 3 cycles.
  - Sequence resumes with B2, C3, D4; total 7 cycles.
- Flush and reset mid-word:
  - `CLR` pulse after the second slice: no further slices of that word; the next word starts from its first slice; `WORD_CNT` unchanged.
  - `RST`=0 after the second slice: all outputs return to reset values and `WORD_CNT`=0.
- `IN_EMPTY_N`=0 for 20 cycles -> `IN_DEQ`, `OUT_ENQ`, `BUSY` stay 0. Separately, preload `WORD_CNT`=0xFFFF via 65535 words; the next word wraps it to 0x0000.
